// File: rtl/uart_arbiter_pkg.sv
// uart_arbiter_pkg: state encoding and byte width shared by the UART arbiter files
package uart_arbiter_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        TX_WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/uart_arbiter_rr_pick.sv
// uart_arbiter_rr_pick: combinational round-robin selector searching upward from last_i+1
// Ports:
//   req_i    - request vector, one bit per requester
//   last_i   - index of the previous owner
//   winner_o - index of the first requester found after last_i (wrapping)
//   valid_o  - high when any request bit is set
module uart_arbiter_rr_pick
    import uart_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);
    // Walk the distance k from far to near so the nearest requester is the last write.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--)
            for (int j = 0; j < NUM_REQ; j++)
                if (req_i[j] && j == (int'(last_i) + k) % NUM_REQ) begin
                    winner_o = IDX_W'(j);
                    valid_o  = 1'b1;
                end
    end
endmodule

// File: rtl/uart_arbiter.sv
// uart_arbiter: session-based round-robin sharing of one UART between NUM_REQ requesters
// Ports:
//   clk_i, reset_i          - clock, asynchronous active-high reset
//   req_i                   - level session request per requester
//   tx_start_i, tx_data_i   - per-requester send pulse and byte (slice i = [8i+7:8i])
//   gnt_o                   - registered one-hot grant
//   tx_done_out_o           - pulse to owner when its byte has been transmitted
//   rx_done_out_o           - pulse to owner when a byte has been received
//   rx_data_out_o           - last received byte
//   rx_dropped_o            - pulse when a byte arrives with no owner
//   busy_o                  - high while a session is active
//   uart_tx_en_o/_data_o    - start pulse and byte to the UART transmitter
//   uart_tx_done_i          - UART transmitter completion
//   uart_rx_done_i/_data_i  - UART receiver byte-valid and byte
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        tx_start_i,
    input  logic [BYTE_W*NUM_REQ-1:0] tx_data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        tx_done_out_o,
    output logic [NUM_REQ-1:0]        rx_done_out_o,
    output logic [BYTE_W-1:0]         rx_data_out_o,
    output logic                      rx_dropped_o,
    output logic                      busy_o,
    output logic                      uart_tx_en_o,
    output logic [BYTE_W-1:0]         uart_tx_data_o,
    input  logic                      uart_tx_done_i,
    input  logic                      uart_rx_done_i,
    input  logic [BYTE_W-1:0]         uart_rx_data_i
);
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d, last_q, last_d, winner;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, tx_done_q, tx_done_d, rx_done_q, rx_done_d, own_oh;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d, rx_data_q, rx_data_d, start_byte;
    logic                tx_en_q, tx_en_d, drop_q, drop_d, valid, own_req, own_start;

    uart_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (valid)
    );

    assign own_oh    = NUM_REQ'(1) << owner_q;
    assign own_req   = |(req_i & own_oh);
    assign own_start = |(tx_start_i & own_oh);

    always_comb begin
        start_byte = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (own_oh[j]) start_byte = tx_data_i[j*BYTE_W +: BYTE_W];
    end

    // Release beats tx_start in OWNED; TX_WAIT ignores both until the UART finishes.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        tx_done_d = '0;
        case (state_q)
            IDLE: if (valid) begin
                state_d = OWNED;
                owner_d = winner;
                gnt_d   = NUM_REQ'(1) << winner;
            end
            OWNED: if (!own_req) begin
                state_d = IDLE;
                last_d  = owner_q;
                gnt_d   = '0;
            end else if (own_start) begin
                state_d   = TX_WAIT;
                tx_en_d   = 1'b1;
                tx_data_d = start_byte;
            end
            TX_WAIT: if (uart_tx_done_i) begin
                state_d   = OWNED;
                tx_done_d = own_oh;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign rx_data_d = uart_rx_done_i ? uart_rx_data_i : rx_data_q;
    assign rx_done_d = (uart_rx_done_i && state_q != IDLE) ? own_oh : '0;
    assign drop_d    = uart_rx_done_i && state_q == IDLE;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            tx_done_q <= '0;
            rx_done_q <= '0;
            rx_data_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            tx_done_q <= tx_done_d;
            rx_done_q <= rx_done_d;
            rx_data_q <= rx_data_d;
            drop_q    <= drop_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign tx_done_out_o  = tx_done_q;
    assign rx_done_out_o  = rx_done_q;
    assign rx_data_out_o  = rx_data_q;
    assign rx_dropped_o   = drop_q;
    assign busy_o         = state_q != IDLE;
    assign uart_tx_en_o   = tx_en_q;
    assign uart_tx_data_o = tx_data_q;
endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter: directed and randomized checks of uart_arbiter against a session-level model
module tb_uart_arbiter;
    localparam int NR = 2;

    logic            clk = 1'b0, rst = 1'b1;
    logic [NR-1:0]   req = '0, tx_start = '0;
    logic [8*NR-1:0] tx_data = '0;
    logic            utx_done = 1'b0, urx_done = 1'b0;
    logic [7:0]      urx_data = '0;
    logic [NR-1:0]   gnt, tx_done, rx_done;
    logic [7:0]      rx_data_o, tx_data_o;
    logic            rx_drop, busy, tx_en;

    int passed = 0, total = 0;

    int          m_owner, m_last;
    bit          m_tx;
    logic [NR-1:0] e_gnt, e_txdone, e_rxdone;
    logic        e_txen, e_drop;
    logic [7:0]  e_txdata, e_rxdata;

    uart_arbiter #(.NUM_REQ(NR), .IDX_W(2)) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .req_i          (req),
        .tx_start_i     (tx_start),
        .tx_data_i      (tx_data),
        .gnt_o          (gnt),
        .tx_done_out_o  (tx_done),
        .rx_done_out_o  (rx_done),
        .rx_data_out_o  (rx_data_o),
        .rx_dropped_o   (rx_drop),
        .busy_o         (busy),
        .uart_tx_en_o   (tx_en),
        .uart_tx_data_o (tx_data_o),
        .uart_tx_done_i (utx_done),
        .uart_rx_done_i (urx_done),
        .uart_rx_data_i (urx_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [3*NR+18:0] obs();
        return {gnt, tx_en, tx_data_o, tx_done, rx_done, rx_data_o, rx_drop, busy};
    endfunction

    function automatic logic [3*NR+18:0] expv();
        return {e_gnt, e_txen, e_txdata, e_txdone, e_rxdone, e_rxdata, e_drop, m_owner >= 0};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NR - 1; m_tx = 0;
        e_gnt = '0; e_txdone = '0; e_rxdone = '0; e_txen = 0; e_drop = 0;
        e_txdata = '0; e_rxdata = '0;
    endtask

    // Session-level reference: owner = -1 means nobody holds the UART.
    task automatic model_edge();
        int cand;
        e_txen = 0; e_txdone = '0; e_rxdone = '0; e_drop = 0;
        if (urx_done) begin
            e_rxdata = urx_data;
            if (m_owner >= 0) e_rxdone[m_owner] = 1'b1;
            else e_drop = 1'b1;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                cand = (m_last + k) % NR;
                if (m_owner < 0 && req[cand]) m_owner = cand;
            end
        end else if (m_tx) begin
            if (utx_done) begin
                e_txdone[m_owner] = 1'b1;
                m_tx = 0;
            end
        end else if (!req[m_owner]) begin
            m_last = m_owner;
            m_owner = -1;
        end else if (tx_start[m_owner]) begin
            e_txdata = tx_data[8*m_owner +: 8];
            e_txen = 1'b1;
            m_tx = 1;
        end
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        tx_start = '0; utx_done = 1'b0; urx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset();
        tick(); tick();
        total++; if (obs() !== expv()) $display("FAIL reset_state: got %h want %h", obs(), expv()); else passed++;
        total++; if ({gnt, tx_en, busy, tx_data_o, rx_data_o} !== '0) $display("FAIL reset_zero: got %b %b %b %h %h want all 0", gnt, tx_en, busy, tx_data_o, rx_data_o); else passed++;
        rst = 1'b0;
        req = 2'b01; tick();
        tx_data[7:0] = 8'hC3; tx_start = 2'b01; tick(); tick();
        total++; if (obs() !== expv()) $display("FAIL reset_pre_tx: got %h want %h", obs(), expv()); else passed++;
        #2; rst = 1'b1; #1;
        total++; if ({gnt, tx_en, busy} !== '0) $display("FAIL reset_async: got gnt=%b en=%b busy=%b want 0 0 0", gnt, tx_en, busy); else passed++;
        model_reset(); req = '0;
        tick(); rst = 1'b0;
        utx_done = 1'b1; tick();
        total++; if (obs() !== expv()) $display("FAIL reset_late_done: got %h want %h", obs(), expv()); else passed++;
        total++; if ({tx_done, busy} !== '0) $display("FAIL reset_late_done_out: got done=%b busy=%b want 0 0", tx_done, busy); else passed++;
    endtask

    task automatic test_single_session();
        int pulses = 0;
        req = 2'b01; tick();
        total++; if (obs() !== expv()) $display("FAIL single_grant_model: got %h want %h", obs(), expv()); else passed++;
        total++; if (gnt !== 2'b01) $display("FAIL single_grant: got %b want 01", gnt); else passed++;
        tx_data[7:0] = 8'hA5; tx_start = 2'b01; tick();
        total++; if ({tx_en, tx_data_o} !== {1'b1, 8'hA5}) $display("FAIL single_tx_en: got %b %h want 1 a5", tx_en, tx_data_o); else passed++;
        for (int i = 0; i < 19; i++) begin
            tick();
            pulses += int'(tx_en);
            total++; if (obs() !== expv()) $display("FAIL single_wait_%0d: got %h want %h", i, obs(), expv()); else passed++;
        end
        utx_done = 1'b1; tick();
        total++; if ({tx_done, tx_data_o} !== {2'b01, 8'hA5}) $display("FAIL single_done: got %b %h want 01 a5", tx_done, tx_data_o); else passed++;
        total++; if (pulses != 0) $display("FAIL single_extra_en: got %0d extra pulses want 0", pulses); else passed++;
        tick();
        total++; if ({tx_done, busy} !== 3'b001) $display("FAIL single_done_pulse: got done=%b busy=%b want 00 1", tx_done, busy); else passed++;
        req = '0; tick();
        total++; if ({gnt, busy} !== 3'b000) $display("FAIL single_release: got gnt=%b busy=%b want 00 0", gnt, busy); else passed++;
        tick();
    endtask

    task automatic test_contention();
        logic [NR-1:0] want;
        req = '0; rst = 1'b1; tick(); rst = 1'b0;
        req = 2'b11; tick();
        total++; if (gnt !== 2'b01) $display("FAIL contend_first: got %b want 01", gnt); else passed++;
        req = 2'b10; tick();
        total++; if ({gnt, busy} !== 3'b000) $display("FAIL contend_bubble: got gnt=%b busy=%b want 00 0", gnt, busy); else passed++;
        tick();
        total++; if (gnt !== 2'b10) $display("FAIL contend_second: got %b want 10", gnt); else passed++;
        for (int s = 0; s < 6; s++) begin
            req = 2'b11; tick();
            req = 2'b11 & ~gnt; tick();
            req = 2'b11; tick();
            want = (s % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (gnt !== want) $display("FAIL fair_%0d: got %b want %b", s, gnt, want); else passed++;
            total++; if (obs() !== expv()) $display("FAIL fair_model_%0d: got %h want %h", s, obs(), expv()); else passed++;
        end
        req = '0; tick(); tick();
    endtask

    task automatic test_dup_start();
        req = 2'b01; tick();
        tx_data = {8'h33, 8'h5C}; tx_start = 2'b01; tick();
        total++; if ({tx_en, tx_data_o} !== {1'b1, 8'h5C}) $display("FAIL dup_first: got %b %h want 1 5c", tx_en, tx_data_o); else passed++;
        tx_data = {8'h33, 8'h44}; tx_start = 2'b11; tick();
        total++; if ({tx_en, tx_data_o} !== {1'b0, 8'h5C}) $display("FAIL dup_both: got %b %h want 0 5c", tx_en, tx_data_o); else passed++;
        tx_start = 2'b10; tick();
        total++; if ({tx_en, tx_data_o} !== {1'b0, 8'h5C}) $display("FAIL dup_nonowner: got %b %h want 0 5c", tx_en, tx_data_o); else passed++;
        utx_done = 1'b1; tick();
        total++; if (tx_done !== 2'b01) $display("FAIL dup_done: got %b want 01", tx_done); else passed++;
        tx_start = 2'b10; tick();
        total++; if ({tx_en, busy, tx_data_o} !== {2'b01, 8'h5C}) $display("FAIL dup_owned_nonowner: got en=%b busy=%b %h want 0 1 5c", tx_en, busy, tx_data_o); else passed++;
        total++; if (obs() !== expv()) $display("FAIL dup_model: got %h want %h", obs(), expv()); else passed++;
        req = '0; tick(); tick();
    endtask

    task automatic test_rx_routing();
        req = 2'b10; tick();
        total++; if (gnt !== 2'b10) $display("FAIL rx_grant: got %b want 10", gnt); else passed++;
        urx_data = 8'h7E; urx_done = 1'b1; tick();
        total++; if ({rx_done, rx_data_o, rx_drop} !== {2'b10, 8'h7E, 1'b0}) $display("FAIL rx_owner: got %b %h %b want 10 7e 0", rx_done, rx_data_o, rx_drop); else passed++;
        tick();
        total++; if (rx_done !== 2'b00) $display("FAIL rx_pulse: got %b want 00", rx_done); else passed++;
        req = '0; tick(); tick();
        urx_data = 8'h11; urx_done = 1'b1; tick();
        total++; if ({rx_done, rx_data_o, rx_drop} !== {2'b00, 8'h11, 1'b1}) $display("FAIL rx_drop: got %b %h %b want 00 11 1", rx_done, rx_data_o, rx_drop); else passed++;
        tick();
        total++; if (rx_drop !== 1'b0) $display("FAIL rx_drop_pulse: got %b want 0", rx_drop); else passed++;
    endtask

    task automatic test_release_collision();
        req = 2'b01; tick();
        total++; if (gnt !== 2'b01) $display("FAIL coll_grant: got %b want 01", gnt); else passed++;
        req = '0; tx_data[7:0] = 8'hE7; tx_start = 2'b01; tick();
        total++; if ({gnt, tx_en, busy} !== '0) $display("FAIL coll_release: got gnt=%b en=%b busy=%b want 00 0 0", gnt, tx_en, busy); else passed++;
        total++; if (tx_data_o === 8'hE7) $display("FAIL coll_data: got %h want not e7", tx_data_o); else passed++;
        tick();
        total++; if (obs() !== expv()) $display("FAIL coll_model: got %h want %h", obs(), expv()); else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) req = NR'($urandom);
            tx_start = NR'($urandom) & NR'($urandom);
            tx_data  = (8*NR)'($urandom);
            utx_done = ($urandom_range(0, 5) == 0);
            urx_done = ($urandom_range(0, 3) == 0);
            urx_data = 8'($urandom);
            if (c == 300) rst = 1'b1;
            tick();
            rst = 1'b0;
            total++; if (obs() !== expv()) $display("FAIL random_%0d: got %h want %h", c, obs(), expv()); else passed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_session();
        test_contention();
        test_dup_start();
        test_rx_routing();
        test_release_collision();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
